// File: rtl/morse_seq_scheduler_pkg.sv
// Shared definitions for morse pattern sequencing: pattern codes, one-hot commands, scheduler states.
package morse_seq_scheduler_pkg;

    localparam logic [1:0] CODE_SSS = 2'd0;
    localparam logic [1:0] CODE_SOS = 2'd1;
    localparam logic [1:0] CODE_OSO = 2'd2;
    localparam logic [1:0] CODE_OOO = 2'd3;

    localparam logic [3:0] CMD_SSS  = 4'b1000;
    localparam logic [3:0] CMD_SOS  = 4'b0100;
    localparam logic [3:0] CMD_OSO  = 4'b0010;
    localparam logic [3:0] CMD_OOO  = 4'b0001;

    localparam logic [2:0] MAX_LEN  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/morse_cmd_decode.sv
// Pattern code to one-hot command for the morse function module.
// Purely combinational, zero latency, no flow control.
module morse_cmd_decode
    import morse_seq_scheduler_pkg::*;
(
    input  logic [1:0] code,
    output logic [3:0] cmd
);

    always_comb begin
        cmd = CMD_SSS;
        case (code)
            CODE_SSS: cmd = CMD_SSS;
            CODE_SOS: cmd = CMD_SOS;
            CODE_OSO: cmd = CMD_OSO;
            CODE_OOO: cmd = CMD_OOO;
            default:  cmd = CMD_SSS;
        endcase
    end

endmodule

// File: rtl/morse_seq_scheduler.sv
// Issues up to four morse patterns in turn, waiting for each cmd_done and a silent gap between them.
// All outputs registered; first command one cycle after start, next one GAP_CYCLES after each cmd_done.
module morse_seq_scheduler
    import morse_seq_scheduler_pkg::*;
#(
    parameter int GAP_CYCLES = 25_000_000,
    parameter int GAP_W      = 25
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_sig,
    input  logic       abort_sig,
    input  logic       loop_en,
    input  logic [2:0] seq_len,
    input  logic [7:0] seq_codes,
    input  logic       cmd_done_sig,
    output logic       func_en_sig,
    output logic [3:0] cmd_start_sig,
    output logic       busy_sig,
    output logic       seq_done_sig,
    output logic [1:0] cur_index
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [1:0]       idx_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic [2:0]       len_q;
    logic [7:0]       codes_q;
    logic             loop_q;
    logic             cfg_ld;
    logic [2:0]       len_in;
    logic             last_entry;
    logic [1:0]       code_sel;
    logic [3:0]       cmd_dec;
    logic             func_en_d, busy_d, seq_done_d;
    logic [3:0]       cmd_d;

    assign len_in     = clamp_len(seq_len);
    assign last_entry = (({1'b0, cur_index} + 3'd1) == len_q);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            cur_index     <= 2'd0;
            cnt_q         <= '0;
            len_q         <= 3'd0;
            codes_q       <= 8'd0;
            loop_q        <= 1'b0;
            func_en_sig   <= 1'b0;
            cmd_start_sig <= 4'b0000;
            busy_sig      <= 1'b0;
            seq_done_sig  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_index     <= idx_d;
            cnt_q         <= cnt_d;
            if (cfg_ld) begin
                len_q   <= len_in;
                codes_q <= seq_codes;
                loop_q  <= loop_en;
            end
            func_en_sig   <= func_en_d;
            cmd_start_sig <= cmd_d;
            busy_sig      <= busy_d;
            seq_done_sig  <= seq_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = cur_index;
        cnt_d   = cnt_q;
        cfg_ld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_sig && (len_in != 3'd0)) begin
                    cfg_ld  = 1'b1;
                    state_d = RUN;
                    idx_d   = 2'd0;
                end
            end
            RUN: begin
                if (cmd_done_sig) begin
                    if (last_entry && !loop_q) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        state_d = GAP;
                        idx_d   = last_entry ? 2'd0 : cur_index + 2'd1;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // abort wins over start and cmd_done arriving in the same cycle
        if (abort_sig) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            cfg_ld  = 1'b0;
        end
    end

    // Entering RUN from IDLE uses the live codes, since the latch happens on this same edge
    assign code_sel = (state_q == IDLE) ? seq_codes[1:0] : codes_q[{idx_d, 1'b0} +: 2];

    morse_cmd_decode u_cmd_decode (
        .code (code_sel),
        .cmd  (cmd_dec)
    );

    always_comb begin
        func_en_d  = (state_d == RUN);
        cmd_d      = func_en_d ? cmd_dec : 4'b0000;
        busy_d     = (state_d != IDLE);
        seq_done_d = !abort_sig &&
                     (((state_q == IDLE) && start_sig && (len_in == 3'd0)) ||
                      ((state_q == RUN) && cmd_done_sig && last_entry && !loop_q));
    end

endmodule

// File: tb/tb_morse_seq_scheduler.sv
// Directed bench for morse_seq_scheduler with a 4-cycle gap.
module tb_morse_seq_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start_sig = 1'b0;
    logic       abort_sig = 1'b0;
    logic       loop_en = 1'b0;
    logic [2:0] seq_len = 3'd0;
    logic [7:0] seq_codes = 8'd0;
    logic       cmd_done_sig = 1'b0;
    logic       func_en_sig;
    logic [3:0] cmd_start_sig;
    logic       busy_sig;
    logic       seq_done_sig;
    logic [1:0] cur_index;

    int tests = 0;
    int fails = 0;

    morse_seq_scheduler #(.GAP_CYCLES(4), .GAP_W(3)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start_sig     (start_sig),
        .abort_sig     (abort_sig),
        .loop_en       (loop_en),
        .seq_len       (seq_len),
        .seq_codes     (seq_codes),
        .cmd_done_sig  (cmd_done_sig),
        .func_en_sig   (func_en_sig),
        .cmd_start_sig (cmd_start_sig),
        .busy_sig      (busy_sig),
        .seq_done_sig  (seq_done_sig),
        .cur_index     (cur_index)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start_sig = 1'b1;
        tick();
        start_sig = 1'b0;
    endtask

    task automatic pulse_done();
        cmd_done_sig = 1'b1;
        tick();
        cmd_done_sig = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".cmd"},  {4'd0, cmd_start_sig}, 8'h00);
        chk({tag, ".en"},   {7'd0, func_en_sig},   8'h00);
        chk({tag, ".busy"}, {7'd0, busy_sig},      8'h00);
        chk({tag, ".done"}, {7'd0, seq_done_sig},  8'h00);
        chk({tag, ".idx"},  {6'd0, cur_index},     8'h00);
    endtask

    logic [3:0] exp_cmd [4];

    initial begin
        exp_cmd = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

        // reset state
        #2;
        chk_idle("rst");
        tick();
        RST = 1'b0;
        tick();
        chk_idle("post_rst");

        // two entries SOS then SSS, no loop
        seq_len = 3'd2; seq_codes = 8'b0000_0001; loop_en = 1'b0;
        pulse_start();
        chk("t1.cmd0", {4'd0, cmd_start_sig}, 8'h04);
        chk("t1.en0",  {7'd0, func_en_sig},   8'h01);
        chk("t1.busy", {7'd0, busy_sig},      8'h01);
        tick();
        chk("t1.hold", {4'd0, cmd_start_sig}, 8'h04);
        pulse_done();
        chk("t1.gap_cmd", {4'd0, cmd_start_sig}, 8'h00);
        chk("t1.gap_en",  {7'd0, func_en_sig},   8'h00);
        chk("t1.gap_busy",{7'd0, busy_sig},      8'h01);
        chk("t1.gap_idx", {6'd0, cur_index},     8'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1.gap_quiet", {4'd0, cmd_start_sig}, 8'h00);
        end
        tick();
        chk("t1.cmd1", {4'd0, cmd_start_sig}, 8'h08);
        pulse_done();
        chk("t1.seq_done", {7'd0, seq_done_sig}, 8'h01);
        chk("t1.busy_drop",{7'd0, busy_sig},     8'h00);
        chk("t1.end_cmd",  {4'd0, cmd_start_sig},8'h00);
        chk("t1.end_idx",  {6'd0, cur_index},    8'h00);
        tick();
        chk("t1.done_once",{7'd0, seq_done_sig}, 8'h00);

        // seq_len 7 clamps to 4 entries
        seq_len = 3'd7; seq_codes = 8'b11_10_01_00;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk("t2.cmd", {4'd0, cmd_start_sig}, {4'd0, exp_cmd[i]});
            chk("t2.idx", {6'd0, cur_index}, 8'(i));
            pulse_done();
            if (i < 3) begin
                chk("t2.no_done", {7'd0, seq_done_sig}, 8'h00);
                repeat (4) tick();
            end else begin
                chk("t2.done", {7'd0, seq_done_sig}, 8'h01);
                chk("t2.busy", {7'd0, busy_sig},     8'h00);
            end
        end
        tick();
        chk_idle("t2.after");

        // single-entry loop of OOO, config changes ignored mid-run, then abort
        seq_len = 3'd1; seq_codes = 8'b0000_0011; loop_en = 1'b1;
        pulse_start();
        loop_en = 1'b0; seq_len = 3'd0; seq_codes = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("t3.cmd", {4'd0, cmd_start_sig}, 8'h01);
            pulse_done();
            chk("t3.no_done", {7'd0, seq_done_sig}, 8'h00);
            chk("t3.busy",    {7'd0, busy_sig},     8'h01);
            chk("t3.gap_cmd", {4'd0, cmd_start_sig},8'h00);
            repeat (4) tick();
        end
        chk("t3.cmd4", {4'd0, cmd_start_sig}, 8'h01);
        abort_sig = 1'b1;
        tick();
        abort_sig = 1'b0;
        chk_idle("t3.abort");

        // start while busy is ignored; spurious cmd_done in GAP and IDLE
        seq_len = 3'd2; seq_codes = 8'b0000_1110; loop_en = 1'b0;
        pulse_start();
        chk("t4.cmd0", {4'd0, cmd_start_sig}, 8'h02);
        seq_len = 3'd1; seq_codes = 8'b0000_0000; loop_en = 1'b1;
        pulse_start();
        chk("t4.cmd0_kept", {4'd0, cmd_start_sig}, 8'h02);
        chk("t4.idx0_kept", {6'd0, cur_index},     8'h00);
        pulse_done();
        pulse_done();
        chk("t4.gap_spur", {4'd0, cmd_start_sig}, 8'h00);
        chk("t4.gap_idx",  {6'd0, cur_index},     8'h01);
        repeat (3) tick();
        chk("t4.cmd1", {4'd0, cmd_start_sig}, 8'h01);
        pulse_done();
        chk("t4.done", {7'd0, seq_done_sig}, 8'h01);
        chk("t4.busy", {7'd0, busy_sig},     8'h00);
        pulse_done();
        chk_idle("t4.idle_spur");

        // abort + start + cmd_done together in RUN
        seq_len = 3'd2; seq_codes = 8'b0000_0001; loop_en = 1'b0;
        pulse_start();
        chk("t5.cmd", {4'd0, cmd_start_sig}, 8'h04);
        abort_sig = 1'b1; start_sig = 1'b1; cmd_done_sig = 1'b1;
        tick();
        abort_sig = 1'b0; start_sig = 1'b0; cmd_done_sig = 1'b0;
        chk_idle("t5.abort_all");
        tick();
        chk_idle("t5.stay");

        // zero-length start
        seq_len = 3'd0;
        pulse_start();
        chk("t5.zero_done", {7'd0, seq_done_sig}, 8'h01);
        chk("t5.zero_busy", {7'd0, busy_sig},     8'h00);
        chk("t5.zero_cmd",  {4'd0, cmd_start_sig},8'h00);
        tick();
        chk("t5.zero_once", {7'd0, seq_done_sig}, 8'h00);

        // reset during GAP clears outputs asynchronously
        seq_len = 3'd2; seq_codes = 8'b0000_0001;
        pulse_start();
        pulse_done();
        tick();
        chk("t6.in_gap", {7'd0, busy_sig}, 8'h01);
        #2 RST = 1'b1;
        #1;
        chk_idle("t6.async_rst");
        #2 RST = 1'b0;
        repeat (8) tick();
        chk_idle("t6.no_reissue");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morse_seq_scheduler.md
Name: morse_seq_scheduler

Overview:
- Sequences the morse pattern function module through a list of up to 4 patterns (SSS/SOS/OSO/OOO).
- Drives the module's one-hot cmd_start_sig and func_en_sig, waits for its cmd_done_sig handshake, then inserts a programmable silent gap before the next pattern.
- Optional continuous looping; replaces the fixed single-command control stage in front of the function module.

Parameters:
- GAP_CYCLES, 25_000_000 — silent cycles between patterns (0.5 s at 50 MHz); legal range ≥1.
- GAP_W, 25 — gap counter width; must hold GAP_CYCLES-1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- start_sig  in  1  one-cycle pulse; starts a sequence.
- abort_sig  in  1  level/pulse; stops the sequence immediately.
- loop_en  in  1  1 = repeat the sequence until abort.
- seq_len  in  3  number of entries, 0..7; values >4 are clamped to 4.
- seq_codes  in  8  entry i = seq_codes[2i+1:2i]; 0=SSS, 1=SOS, 2=OSO, 3=OOO.
- cmd_done_sig  in  1  one-cycle pulse from the function module when the current pattern finishes.
- func_en_sig  out  1  enable to the function module.
- cmd_start_sig  out  4  one-hot command: SSS=1000, SOS=0100, OSO=0010, OOO=0001.
- busy_sig  out  1  high while not IDLE.
- seq_done_sig  out  1  one-cycle pulse when a non-looping sequence completes.
- cur_index  out  2  index of the entry being issued or next to issue.

Behaviour:
- All outputs are registered. Reset values: func_en_sig=0, cmd_start_sig=0000, busy_sig=0, seq_done_sig=0, cur_index=0, state=IDLE, gap counter=0.
- States: IDLE, RUN, GAP.

IDLE:
- On start_sig=1 with clamped seq_len≠0, latch seq_len (clamped), seq_codes and loop_en, then go to RUN.
  - Latency: start at cycle N; func_en_sig=1 and cmd_start_sig=decode(entry 0) at N+1; busy_sig=1 at N+1.
- On start_sig=1 with seq_len=0: stay in IDLE and pulse seq_done_sig at N+1.
- cmd_done_sig is ignored in IDLE.

RUN:
- Holds func_en_sig=1 and cmd_start_sig=decode(latched entry cur_index) stable until cmd_done_sig.
- On cmd_done_sig at cycle M, func_en_sig=0 and cmd_start_sig=0000 at M+1. Then:
  - Last entry and latched loop_en=0: go to IDLE; seq_done_sig=1 at M+1 only; busy_sig=0 at M+1; cur_index returns to 0.
  - Otherwise: cur_index increments, wrapping to 0 after the last entry when looping. Load the gap counter with GAP_CYCLES-1 and go to GAP.

GAP:
- Outputs stay at 0; the counter decrements each cycle.
- On the cycle the counter is 0, go to RUN. Outputs reassert at M+1+GAP_CYCLES with the new entry.
- cmd_done_sig is ignored in GAP.

Precedence and boundary rules:
- start_sig while busy_sig=1 is ignored; latched configuration is not disturbed.
- Input changes to seq_codes, seq_len or loop_en mid-sequence have no effect until the next accepted start.
- abort_sig=1 in any state forces IDLE next cycle: outputs 0, cur_index 0, no seq_done_sig.
  - abort_sig has priority over start_sig and over cmd_done_sig in the same cycle.
- A single-entry sequence with loop_en=1 repeats the same pattern with a gap between repetitions.
- RST assertion mid-operation returns everything to reset values asynchronously. After deassertion the block waits in IDLE for a fresh start_sig.

Decomposition:
- Shared package holds:
  - code constants CODE_SSS=0, CODE_SOS=1, CODE_OSO=2, CODE_OOO=3;
  - one-hot constants CMD_SSS=4'b1000 … CMD_OOO=4'b0001;
  - state encoding IDLE/RUN/GAP.
- One natural sub-module, morse_cmd_decode: combinational 2-bit code → 4-bit one-hot. It is reused by any other pattern controller.
- The gap counter stays inline.

Test Plan (GAP_CYCLES=4 for simulation):
- Reset, then start with seq_len=2, seq_codes=8'b0000_0001 (SOS, SSS), loop_en=0.
  - Expect cmd_start_sig=0100 one cycle after start. After cmd_done, 0000 for exactly 4 cycles, then 1000.
  - After the second cmd_done, seq_done_sig pulses once and busy_sig drops on the same cycle.
- seq_len=7, codes 8'b11_10_01_00 → exactly 4 patterns in order 1000, 0100, 0010, 0001, then one seq_done_sig.
- loop_en=1, seq_len=1, code OOO → 0001 is reissued after every cmd_done + 4-cycle gap for 3 iterations, with no seq_done_sig. Then abort_sig → outputs 0 next cycle, no seq_done_sig.
- Start while busy with different codes → ignored; the original sequence completes unchanged. Spurious cmd_done in GAP/IDLE → no state change.
- abort_sig, start_sig and cmd_done_sig in the same cycle during RUN → IDLE, outputs 0, no seq_done_sig, no advance. seq_len=0 start → a single seq_done_sig pulse, and busy_sig stays 0.
- Assert RST during GAP → all outputs 0 immediately. After release, nothing is issued until a new start_sig.
